// File: rtl/lpf_pkg.sv
// Shared constants and qualifier state type for the multi-channel encoder input filter.
package lpf_pkg;

  localparam int unsigned LPF_CNT_W       = 14;
  localparam int unsigned LPF_SYNC_STAGES = 2;
  localparam int unsigned LPF_GCNT_W      = 16;

  typedef enum logic {
    MATCH = 1'b0,
    PEND  = 1'b1
  } lpf_state_e;

endpackage

// File: rtl/lpf_chan.sv
// One filter channel: synchroniser, consecutive-sample qualifier, edge strobes.
// LPF_GLITCH_CNT_EN adds a saturating counter of rejected glitches.
module lpf_chan
  import lpf_pkg::*;
#(
  parameter int unsigned CNT_W       = LPF_CNT_W,
  parameter int unsigned SYNC_STAGES = LPF_SYNC_STAGES
`ifdef LPF_GLITCH_CNT_EN
  ,
  parameter int unsigned GCNT_W      = LPF_GCNT_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] thresh,
  output logic             sig_filter,
  output logic             edge_rise,
  output logic             edge_fall
`ifdef LPF_GLITCH_CNT_EN
  ,
  input  logic              glitch_clr,
  output logic [GCNT_W-1:0] glitch_cnt
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [CNT_W:0]         n;
  logic                   f_nxt;
  logic                   rise_nxt;
  logic                   fall_nxt;
  lpf_state_e             state;

  // Input synchroniser; s is sig_in delayed by SYNC_STAGES edges
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
  end

  assign s     = sync_q[SYNC_STAGES-1];
  assign state = (s != sig_filter) ? PEND : MATCH;

  // Qualifier: count consecutive disagreeing samples; thresh of 0 behaves as 1
  always_comb begin
    cnt_nxt  = cnt;
    f_nxt    = sig_filter;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    n        = {1'b0, cnt} + (CNT_W+1)'(1);
    case (state)
      MATCH: cnt_nxt = '0;
      PEND: begin
        if (n >= {1'b0, thresh}) begin
          f_nxt    = s;
          cnt_nxt  = '0;
          rise_nxt = s;
          fall_nxt = ~s;
        end else begin
          cnt_nxt = n[CNT_W-1:0];
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      sig_filter <= 1'b0;
      edge_rise  <= 1'b0;
      edge_fall  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      sig_filter <= f_nxt;
      edge_rise  <= rise_nxt;
      edge_fall  <= fall_nxt;
    end
  end

`ifdef LPF_GLITCH_CNT_EN
  localparam logic [GCNT_W-1:0] GCNT_MAX = '1;

  logic glitch;

  // An excursion that ended while still counting was rejected
  assign glitch = (state == MATCH) && (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset || glitch_clr)                   glitch_cnt <= '0;
    else if (glitch && (glitch_cnt != GCNT_MAX)) glitch_cnt <= glitch_cnt + GCNT_W'(1);
  end
`endif

endmodule

// File: rtl/lpf_multi_enc.sv
// Multi-channel encoder input debounce filter: NCH independent lpf_chan instances.
// LPF_GLITCH_CNT_EN enables per-channel rejected-glitch counters.
module lpf_multi_enc
  import lpf_pkg::*;
#(
  parameter int unsigned NCH         = 3,
  parameter int unsigned CNT_W       = LPF_CNT_W,
  parameter int unsigned SYNC_STAGES = LPF_SYNC_STAGES
`ifdef LPF_GLITCH_CNT_EN
  ,
  parameter int unsigned GCNT_W      = LPF_GCNT_W
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       sig_in,
  input  logic [NCH*CNT_W-1:0] thresh,
  output logic [NCH-1:0]       sig_filter,
  output logic [NCH-1:0]       edge_rise,
  output logic [NCH-1:0]       edge_fall
`ifdef LPF_GLITCH_CNT_EN
  ,
  input  logic                  glitch_clr,
  output logic [NCH*GCNT_W-1:0] glitch_cnt
`endif
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    lpf_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef LPF_GLITCH_CNT_EN
      ,
      .GCNT_W      (GCNT_W)
`endif
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig_in[i]),
      .thresh     (thresh[i*CNT_W +: CNT_W]),
      .sig_filter (sig_filter[i]),
      .edge_rise  (edge_rise[i]),
      .edge_fall  (edge_fall[i])
`ifdef LPF_GLITCH_CNT_EN
      ,
      .glitch_clr (glitch_clr),
      .glitch_cnt (glitch_cnt[i*GCNT_W +: GCNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_lpf_multi_enc.sv
// Self-checking bench for lpf_multi_enc: directed cases plus randomized traffic
// against a history-based reference model. Glitch checks under LPF_GLITCH_CNT_EN.
module tb_lpf_multi_enc;

  localparam int unsigned NCH    = 3;
  localparam int unsigned CNT_W  = 14;
  localparam int unsigned SS     = 2;
  localparam int unsigned GCNT_W = 4;
  localparam int unsigned GMAX   = (1 << GCNT_W) - 1;

  logic                 clk;
  logic                 reset;
  logic [NCH-1:0]       sig_in;
  logic [NCH*CNT_W-1:0] thresh;
  logic [NCH-1:0]       sig_filter;
  logic [NCH-1:0]       edge_rise;
  logic [NCH-1:0]       edge_fall;
`ifdef LPF_GLITCH_CNT_EN
  logic                  glitch_clr;
  logic [NCH*GCNT_W-1:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  lpf_multi_enc #(
    .NCH         (NCH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SS)
`ifdef LPF_GLITCH_CNT_EN
    ,
    .GCNT_W      (GCNT_W)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .thresh     (thresh),
    .sig_filter (sig_filter),
    .edge_rise  (edge_rise),
    .edge_fall  (edge_fall)
`ifdef LPF_GLITCH_CNT_EN
    ,
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: keep the synchronised sample history; a channel follows its
  // input once the trailing run of samples differing from the output reaches thresh.
  logic [NCH-1:0] inq[$];
  logic [NCH-1:0] sh[$];
  logic [NCH-1:0] mf, mr, mfl;
  int unsigned    mg[NCH];

  always @(posedge clk) begin
    logic [NCH-1:0] s_v, nf;
    int             r;
    int unsigned    thr;
    bit             gl;
    if (reset) begin
      inq.delete();
      for (int k = 0; k < SS; k++) inq.push_back('0);
      sh.delete();
      mf  = '0;
      mr  = '0;
      mfl = '0;
      for (int i = 0; i < NCH; i++) mg[i] = 0;
    end else begin
      s_v = inq.pop_front();
      inq.push_back(sig_in);
      sh.push_back(s_v);
      if (sh.size() > 512) void'(sh.pop_front());
      nf  = mf;
      mr  = '0;
      mfl = '0;
      for (int i = 0; i < NCH; i++) begin
        thr = int'(thresh[i*CNT_W +: CNT_W]);
        if (thr == 0) thr = 1;
        gl = 1'b0;
        if (s_v[i] != mf[i]) begin
          r = 0;
          for (int k = sh.size() - 1; k >= 0 && sh[k][i] != mf[i]; k--) r++;
          if (r >= int'(thr)) begin
            nf[i]  = s_v[i];
            mr[i]  = s_v[i];
            mfl[i] = ~s_v[i];
          end
        end else if (sh.size() >= 2) begin
          gl = (sh[sh.size()-2][i] != mf[i]);
        end
`ifdef LPF_GLITCH_CNT_EN
        if (glitch_clr)             mg[i] = 0;
        else if (gl && mg[i] < GMAX) mg[i] = mg[i] + 1;
`else
        if (gl) mg[i] = mg[i] + 1;
`endif
      end
      mf = nf;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare every output against the model
  task automatic tick(input int n = 1);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      @(negedge clk);
      chk("model_filter", 64'(sig_filter), 64'(mf));
      chk("model_rise", 64'(edge_rise), 64'(mr));
      chk("model_fall", 64'(edge_fall), 64'(mfl));
`ifdef LPF_GLITCH_CNT_EN
      for (int i = 0; i < NCH; i++)
        chk("model_glitch", 64'(glitch_cnt[i*GCNT_W +: GCNT_W]), 64'(mg[i]));
`endif
    end
  endtask

  task automatic set_th(input int ch, input int v);
    thresh[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = '0;
    for (int i = 0; i < NCH; i++) set_th(i, 10);
`ifdef LPF_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif
    tick(3);
    chk("rst_filter", 64'(sig_filter), 64'(0));
    chk("rst_rise", 64'(edge_rise), 64'(0));

    // Release with all inputs high: output rises at edge SYNC_STAGES + thresh
    reset  = 1'b0;
    sig_in = 3'b111;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e < 12) chk("t1_hold", 64'(sig_filter), 64'(0));
    end
    chk("t1_filter", 64'(sig_filter), 64'(3'b111));
    chk("t1_rise", 64'(edge_rise), 64'(3'b111));
    tick();
    chk("t1_rise_once", 64'(edge_rise), 64'(0));
    sig_in = '0;
    tick(15);
    chk("t1_back_low", 64'(sig_filter), 64'(0));

    // 9-cycle pulse on ch0 with thresh 10 is rejected
`ifdef LPF_GLITCH_CNT_EN
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
`endif
    sig_in[0] = 1'b1;
    tick(9);
    sig_in[0] = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick();
      chk("t2_filter0", 64'(sig_filter[0]), 64'(0));
      chk("t2_rise0", 64'(edge_rise[0]), 64'(0));
    end
`ifdef LPF_GLITCH_CNT_EN
    chk("t2_glitch0", 64'(glitch_cnt[GCNT_W-1:0]), 64'(1));
`endif

    // Bypass thresholds: 1-cycle pulse passes with 3-edge latency
    for (int th = 0; th < 2; th++) begin
      set_th(1, th);
      sig_in[1] = 1'b1;
      tick();
      sig_in[1] = 1'b0;
      tick();
      tick();
      chk("t3_rise1", 64'(edge_rise[1]), 64'(1));
      chk("t3_filter1", 64'(sig_filter[1]), 64'(1));
      tick();
      chk("t3_fall1", 64'(edge_fall[1]), 64'(1));
      chk("t3_filter1_low", 64'(sig_filter[1]), 64'(0));
      tick(3);
    end

    // Independent channels: ch1/ch2 qualify together, ch0 (thresh 100) does not
    set_th(0, 100);
    set_th(1, 5);
    set_th(2, 5);
    sig_in = 3'b111;
    tick(6);
    chk("t4_pre", 64'(sig_filter), 64'(0));
    tick();
    chk("t4_filter", 64'(sig_filter), 64'(3'b110));
    chk("t4_rise", 64'(edge_rise), 64'(3'b110));
    tick(30);
    sig_in[2:1] = 2'b00;
    tick(7);
    chk("t4_fall", 64'(edge_fall), 64'(3'b110));
    sig_in[0] = 1'b0;
    tick(10);
    chk("t4_ch0", 64'(sig_filter), 64'(0));

    // Lowering thresh below the running count qualifies on the next edge
    set_th(2, 50);
    sig_in[2] = 1'b1;
    tick(30);
    chk("t5_pre", 64'(sig_filter[2]), 64'(0));
    set_th(2, 20);
    tick();
    chk("t5_filter2", 64'(sig_filter[2]), 64'(1));
    chk("t5_rise2", 64'(edge_rise[2]), 64'(1));
    sig_in[2] = 1'b0;
    set_th(2, 5);
    tick(10);

`ifdef LPF_GLITCH_CNT_EN
    // Saturation and clear-wins-over-increment
    set_th(0, 5);
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    for (int g = 0; g < 20; g++) begin
      sig_in[0] = 1'b1;
      tick();
      sig_in[0] = 1'b0;
      tick(3);
    end
    tick(3);
    chk("t6_sat", 64'(glitch_cnt[GCNT_W-1:0]), 64'(GMAX));
    glitch_clr = 1'b1;
    sig_in[0]  = 1'b1;
    tick();
    sig_in[0]  = 1'b0;
    tick(4);
    glitch_clr = 1'b0;
    tick();
    chk("t6_clr", 64'(glitch_cnt[GCNT_W-1:0]), 64'(0));
`endif

    // Randomized traffic, with one reset landing mid-qualification
    for (int it = 0; it < 1500; it++) begin
      if (it % 100 == 0)
        for (int i = 0; i < NCH; i++) set_th(i, int'($urandom_range(0, 8)));
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 3) == 0) sig_in[i] = ~sig_in[i];
`ifdef LPF_GLITCH_CNT_EN
      glitch_clr = ($urandom_range(0, 63) == 0);
`endif
      if (it == 700) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
